// File: rtl/gopf_poly_div_pkg.sv
// gopf_pkg: shared types, field defaults and degree encoder
// for the GF(2^W)[x] polynomial divider.
package gopf_pkg;

  typedef enum logic [2:0] {
    IDLE, DEG, INV, LEAD, SUB, DONE
  } state_t;

  localparam int GOPF_W = 16;
  localparam int GOPF_N = 9;
  localparam logic [16:0] GOPF_FIELD_POLY = 17'h1002D;
  localparam int DEG_W = $clog2(GOPF_N + 1);
  localparam int MAX_C = 64;

  // index of the highest nonzero coefficient; 0 for an all-zero mask
  function automatic int deg_of(input logic [MAX_C-1:0] nz);
    deg_of = 0;
    for (int i = 0; i < MAX_C; i++)
      if (nz[i]) deg_of = i;
  endfunction

endpackage

// File: rtl/gopf_poly_div_if.sv
// gopf_poly_div_if: command/result bus plus inverter
// req/ack channel of the polynomial divider.
interface gopf_poly_div_if
  import gopf_pkg::*;
#(
  parameter int W = GOPF_W,
  parameter int N = GOPF_N
);
  logic                 start;
  logic [(N+1)*W-1:0]   dividend;
  logic [N*W-1:0]       divisor;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [(N+1)*W-1:0]   quotient;
  logic [N*W-1:0]       remainder;
  logic                 inv_req;
  logic [W-1:0]         inv_out;
  logic                 inv_ack;
  logic [W-1:0]         inv_in;

  modport master (
    output start, dividend, divisor,
    output inv_ack, inv_in,
    input  busy, done, err,
    input  quotient, remainder,
    input  inv_req, inv_out
  );

  modport slave (
    input  start, dividend, divisor,
    input  inv_ack, inv_in,
    output busy, done, err,
    output quotient, remainder,
    output inv_req, inv_out
  );
endinterface

// File: rtl/gopf_poly_div_gf2w_mul.sv
// gf2w_mul: combinational GF(2^W) multiply,
// MSB-first shift-and-add reduced by FIELD_POLY.
module gf2w_mul
  import gopf_pkg::*;
#(
  parameter int         W          = GOPF_W,
  parameter logic [W:0] FIELD_POLY = GOPF_FIELD_POLY
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] p_o
);

  logic [W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = W - 1; i >= 0; i--) begin
      acc = {acc[W-2:0], 1'b0}
          ^ (acc[W-1] ? FIELD_POLY[W-1:0] : '0);
      if (b_i[i]) acc = acc ^ a_i;
    end
    p_o = acc;
  end

endmodule

// File: rtl/gopf_poly_div.sv
// gopf_poly_div: long division over GF(2^W)[x], one LEAD/SUB
// pair per quotient term. GOPF_POLY_DIV_INV_CACHE_EN keeps INVR.
module gopf_poly_div
  import gopf_pkg::*;
#(
  parameter int         W          = GOPF_W,
  parameter int         N          = GOPF_N,
  parameter logic [W:0] FIELD_POLY = GOPF_FIELD_POLY
) (
  input logic            clk,
  input logic            rst,
  gopf_poly_div_if.slave bus
);

  localparam int DW = $clog2(N + 1);
  typedef logic [W-1:0] coef_t;

  state_t          state_q, state_d;
  coef_t [N:0]     r_q, r_d, q_q, q_d;
  coef_t [N:0]     quo_q, quo_d;
  coef_t [N-1:0]   b_q, b_d, rem_q, rem_d;
  coef_t           t_q, t_d, invr_q, invr_d;
  coef_t           blc_q, blc_d;
  logic            vld_q, vld_d, err_q, err_d;

  logic [N:0]      nz_r;
  logic [N-1:0]    nz_b;
  logic [DW-1:0]   dr, db, sh;
  coef_t           r_top, b_top, lead;
  coef_t [N-1:0]   tb;
  coef_t [N:0]     rsub;
  logic            inv_hit;

  always_comb begin
    nz_r = '0;
    nz_b = '0;
    for (int i = 0; i <= N; i++) nz_r[i] = |r_q[i];
    for (int i = 0; i < N; i++) nz_b[i] = |b_q[i];
  end

  assign dr      = DW'(deg_of(MAX_C'(nz_r)));
  assign db      = DW'(deg_of(MAX_C'(nz_b)));
  assign sh      = dr - db;
  assign r_top   = r_q[dr];
  assign b_top   = b_q[db];
  assign inv_hit = vld_q && (b_top == blc_q);

  for (genvar j = 0; j < N; j++) begin : g_tb
    gf2w_mul #(.W(W), .FIELD_POLY(FIELD_POLY)) u_mul (
      .a_i (t_q),
      .b_i (b_q[j]),
      .p_o (tb[j])
    );
  end

  gf2w_mul #(.W(W), .FIELD_POLY(FIELD_POLY)) u_lead (
    .a_i (r_top),
    .b_i (invr_q),
    .p_o (lead)
  );

  // x^sh * T * B; terms above x^N are zero by construction
  always_comb begin
    rsub = '0;
    for (int i = 0; i <= N; i++)
      for (int j = 0; j < N; j++)
        if (i == j + int'(sh)) rsub[i] = rsub[i] ^ tb[j];
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    b_d     = b_q;
    q_d     = q_q;
    t_d     = t_q;
    invr_d  = invr_q;
    blc_d   = blc_q;
    vld_d   = vld_q;
    err_d   = err_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        r_d   = bus.dividend;
        b_d   = bus.divisor;
        q_d   = '0;
        err_d = 1'b0;
        quo_d = '0;
        rem_d = '0;
`ifdef GOPF_POLY_DIV_INV_CACHE_EN
        vld_d = vld_q;
`else
        vld_d = 1'b0;
`endif
        state_d = DEG;
      end
      DEG: begin
        if (nz_b == '0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (nz_r == '0 || dr < db) begin
          quo_d   = q_q;
          rem_d   = r_q[N-1:0];
          state_d = DONE;
        end else if (!inv_hit) begin
          state_d = INV;
        end else begin
          state_d = LEAD;
        end
      end
      INV: if (bus.inv_ack) begin
        invr_d  = bus.inv_in;
        blc_d   = b_top;
        vld_d   = 1'b1;
        state_d = LEAD;
      end
      LEAD: begin
        t_d     = lead;
        state_d = SUB;
      end
      SUB: begin
        r_d     = r_q ^ rsub;
        q_d[sh] = q_q[sh] ^ t_q;
        state_d = DEG;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      t_q     <= '0;
      invr_q  <= '0;
      blc_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      b_q     <= b_d;
      q_q     <= q_d;
      t_q     <= t_d;
      invr_q  <= invr_d;
      blc_q   <= blc_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.inv_req   = (state_q == INV);
  assign bus.inv_out   = bus.inv_req ? b_top : '0;

endmodule

// File: tb/tb_gopf_poly_div.sv
// tb_gopf_poly_div: directed vectors for gopf_poly_div with
// an inverter stub; expected values worked out by hand.
module tb_gopf_poly_div;

  localparam int W = 16;
  localparam int N = 9;

  logic clk;
  logic rst;

  gopf_poly_div_if #(.W(W), .N(N)) dif ();

  gopf_poly_div #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // inverter stub: acks after ack_dly wait cycles in INV
  logic         stub_en;
  int           ack_dly;
  logic [W-1:0] ack_val;
  logic         stub_ack = 1'b0;
  logic [W-1:0] stub_val = '0;
  int           wait_n = 0;
  logic         late_ack;
  logic [W-1:0] late_val;

  always @(negedge clk) begin
    if (stub_en && dif.inv_req) begin
      if (wait_n >= ack_dly) begin
        stub_ack <= 1'b1;
        stub_val <= ack_val;
      end else begin
        stub_ack <= 1'b0;
        wait_n   <= wait_n + 1;
      end
    end else begin
      stub_ack <= 1'b0;
      wait_n   <= 0;
    end
  end

  assign dif.inv_ack = stub_ack | late_ack;
  assign dif.inv_in  = late_ack ? late_val : stub_val;

  // rising edges of inv_req
  int   n_req = 0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    if (dif.inv_req && !req_prev) n_req <= n_req + 1;
    req_prev <= dif.inv_req;
  end

  task automatic chk(input string tag,
                     input logic [159:0] obs,
                     input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input  logic [(N+1)*W-1:0] a,
                     input  logic [N*W-1:0]     b,
                     input  logic [W-1:0]       exp_iout,
                     output int                 lat,
                     output int                 icyc,
                     output int                 ibad);
    int cyc;
    lat  = -1;
    icyc = 0;
    ibad = 0;
    @(negedge clk);
    dif.dividend = a;
    dif.divisor  = b;
    dif.start    = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    cyc = 1;
    while (cyc < 200 && lat < 0) begin
      if (dif.done) begin
        lat = cyc;
      end else begin
        if (dif.inv_req) begin
          icyc++;
          if (dif.inv_out !== exp_iout) ibad++;
        end
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  logic [(N+1)*W-1:0] a, qe;
  logic [N*W-1:0]     b, re;
  int lat, icyc, ibad, r0;

  initial begin
    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    stub_en      = 1'b0;
    ack_dly      = 0;
    ack_val      = '0;
    late_ack     = 1'b0;
    late_val     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", dif.busy, 0);
    chk("rst_done", dif.done, 0);
    chk("rst_err", dif.err, 0);
    chk("rst_q", dif.quotient, 0);
    chk("rst_r", dif.remainder, 0);
    chk("rst_req", dif.inv_req, 0);
    chk("rst_iout", dif.inv_out, 0);

    // a=x^2, b=x+1, immediate ack of 1
    stub_en = 1'b1;
    ack_dly = 0;
    ack_val = 16'h0001;
    a = '0; a[2*W +: W] = 16'h1;
    b = '0; b[0 +: W] = 16'h1; b[W +: W] = 16'h1;
    run(a, b, 16'h1, lat, icyc, ibad);
    qe = '0; qe[0 +: W] = 16'h1; qe[W +: W] = 16'h1;
    re = '0; re[0 +: W] = 16'h1;
    chk("t1_lat", lat, 9);
    chk("t1_q", dif.quotient, qe);
    chk("t1_r", dif.remainder, re);
    chk("t1_err", dif.err, 0);
    chk("t1_busy", dif.busy, 1);
    chk("t1_iout", ibad, 0);

    // zero divisor
    r0 = n_req;
    a = '0; a[4*W +: W] = 16'h3; a[W +: W] = 16'h1;
    b = '0;
    run(a, b, 16'h0, lat, icyc, ibad);
    chk("t2_lat", lat, 2);
    chk("t2_err", dif.err, 1);
    chk("t2_q", dif.quotient, 0);
    chk("t2_r", dif.remainder, 0);
    chk("t2_noreq", n_req - r0, 0);
    @(negedge clk);
    chk("t2_err_hold", dif.err, 1);
    chk("t2_idle", dif.busy, 0);

    // deg a < deg b
    r0 = n_req;
    a = '0; a[0 +: W] = 16'h0005;
    b = '0; b[W +: W] = 16'h1;
    run(a, b, 16'h0, lat, icyc, ibad);
    re = '0; re[0 +: W] = 16'h0005;
    chk("t3_lat", lat, 2);
    chk("t3_q", dif.quotient, 0);
    chk("t3_r", dif.remainder, re);
    chk("t3_err", dif.err, 0);
    chk("t3_noreq", n_req - r0, 0);

    // a=2x, b=2, ack after 5 wait cycles with inv(2)=0x8016
    ack_dly = 5;
    ack_val = 16'h8016;
    a = '0; a[W +: W] = 16'h2;
    b = '0; b[0 +: W] = 16'h2;
    run(a, b, 16'h2, lat, icyc, ibad);
    qe = '0; qe[W +: W] = 16'h1;
    chk("t4_lat", lat, 11);
    chk("t4_q", dif.quotient, qe);
    chk("t4_r", dif.remainder, 0);
    chk("t4_icyc", icyc, 6);
    chk("t4_iout", ibad, 0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // back-to-back a=x^2, b=2x+1: q=0x8016x+0x400B, r=0x400B
    ack_dly = 0;
    ack_val = 16'h8016;
    r0 = n_req;
    a = '0; a[2*W +: W] = 16'h1;
    b = '0; b[0 +: W] = 16'h1; b[W +: W] = 16'h2;
    qe = '0; qe[0 +: W] = 16'h400B; qe[W +: W] = 16'h8016;
    re = '0; re[0 +: W] = 16'h400B;
    run(a, b, 16'h2, lat, icyc, ibad);
    chk("t5a_lat", lat, 9);
    chk("t5a_q", dif.quotient, qe);
    chk("t5a_r", dif.remainder, re);
    run(a, b, 16'h2, lat, icyc, ibad);
`ifdef GOPF_POLY_DIV_INV_CACHE_EN
    chk("t5b_lat", lat, 8);
    chk("t5_nreq", n_req - r0, 1);
`else
    chk("t5b_lat", lat, 9);
    chk("t5_nreq", n_req - r0, 2);
`endif
    chk("t5b_q", dif.quotient, qe);
    chk("t5b_r", dif.remainder, re);

    // reset while waiting in INV, then a late ack
    stub_en = 1'b0;
    a = '0; a[2*W +: W] = 16'h1;
    b = '0; b[0 +: W] = 16'h1; b[W +: W] = 16'h1;
    @(negedge clk);
    dif.dividend = a;
    dif.divisor  = b;
    dif.start    = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    @(negedge clk);
    chk("t6_inv", dif.inv_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy", dif.busy, 0);
    chk("t6_done", dif.done, 0);
    chk("t6_err", dif.err, 0);
    chk("t6_q", dif.quotient, 0);
    chk("t6_r", dif.remainder, 0);
    chk("t6_req", dif.inv_req, 0);
    chk("t6_iout", dif.inv_out, 0);
    late_ack = 1'b1;
    late_val = 16'h1234;
    @(negedge clk);
    late_ack = 1'b0;
    chk("t6_late_busy", dif.busy, 0);
    chk("t6_late_req", dif.inv_req, 0);
    stub_en = 1'b1;
    ack_val = 16'h0001;
    r0 = n_req;
    run(a, b, 16'h1, lat, icyc, ibad);
    qe = '0; qe[0 +: W] = 16'h1; qe[W +: W] = 16'h1;
    re = '0; re[0 +: W] = 16'h1;
    chk("t6_lat", lat, 9);
    chk("t6_q2", dif.quotient, qe);
    chk("t6_r2", dif.remainder, re);
    chk("t6_nreq", n_req - r0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gopf_poly_div.md
# gopf_poly_div

Parametrised polynomial divider over GF(2^W)[x]. It is the next generation of the fixed 9×16-bit divider in the Goppa-polynomial ALU: coefficient width and coefficient count are set by parameters, and the multiplier array is internal. The divisor leading-coefficient inverse comes from the shared GF(2^W) inverter through a variable-latency req/ack handshake. Zero-divisor detection and an optional inverse cache are included. The block sits in the ALU beside the inverter and is started by the ASIP decoder.

## Interface
- W, 16: coefficient width in bits; field GF(2^W).
- N, 9: divisor and remainder coefficient count. Dividend and quotient carry N+1 coefficients.
- FIELD_POLY, 17'h1002D: field polynomial x^16+x^5+x^3+x^2+1, W+1 bits.
- Packing, all buses: coefficient of x^i occupies bits [i*W +: W].

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- dividend  in  (N+1)*W  dividend a(x), degree ≤ N.
- divisor  in  N*W  divisor b(x), degree ≤ N-1.
- busy  out  1  high from the cycle after start is accepted until DONE inclusive.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  set in DONE when b(x)=0; held until the next start.
- quotient  out  (N+1)*W  q(x); held from DONE until the next start.
- remainder  out  N*W  r(x), deg r < deg b; held from DONE until the next start.
- inv_req  out  1  inverse request; level signal.
- inv_out  out  W  operand for the inverter; stable while inv_req is high.
- inv_ack  in  1  inverter result valid.
- inv_in  in  W  b_lc^-1; valid when inv_ack is high.

## Operation
- Reset: every output is 0. State goes to IDLE, internal registers clear, and the cache valid flag clears.
- IDLE: when start=1, load R←dividend, B←divisor, Q←0, err←0, and clear the quotient and remainder outputs; go to DEG.
- DEG (1 cycle): a combinational priority encoder gives dr=deg R and db=deg B.
  - B=0: err←1, go to DONE.
  - R=0 or dr<db: go to DONE.
  - Inverse not valid: go to INV.
  - Otherwise: go to LEAD.
- INV: drive inv_req=1 and inv_out=B[db]. On inv_ack=1, latch inv_in into INVR, set the valid flag, drop inv_req in the next cycle, and go to LEAD. An ack that arrives in the same cycle inv_req is first raised is legal.
- LEAD (1 cycle): T←R[dr]·INVR.
- SUB (1 cycle): Q[dr-db]←Q[dr-db]^T and R←R^(x^(dr-db)·T·B). R[dr] must become 0. Return to DEG.
- DONE (1 cycle): quotient←Q and remainder←R[N-1:0]. When err=1 both outputs are 0. done=1; next state is IDLE.
- GF multiply is the GF(2) product reduced by FIELD_POLY, with a W-bit result. Subtraction is XOR.
- The shift by dr-db never exceeds N. Bits shifted beyond coefficient N are provably zero and are discarded.
- start while busy is ignored.
- inv_ack outside INV is ignored.
- rst in any state, including INV, aborts immediately: inv_req drops next cycle and a late ack is ignored.

## Timing
- The cycle in which IDLE samples start is cycle 0. DEG is cycle 1.
- done is high in cycle 2+I+3k:
  - I = number of INV cycles (0 if the inverse is reused).
  - k = number of LEAD/SUB iterations, at most N+1.
- Minimum latency: 2 cycles (zero divisor, or deg a < deg b).
- The earliest next start is the cycle after DONE.

## Configuration
- GOPF_POLY_DIV_INV_CACHE_EN defined:
  - INVR and its operand B_lc are kept across divisions.
  - In DEG, if the valid flag is set and B[db]==cached B_lc, INV is skipped (I=0).
- Undefined: the valid flag clears on every accepted start, so every non-trivial division requests an inverse.

## Structure
- Package gopf_pkg holds:
  - the state enum {IDLE, DEG, INV, LEAD, SUB, DONE};
  - the FIELD_POLY default;
  - the degree-width localparam $clog2(N+1).
- Sub-module gf2w_mul: combinational W×W multiply reduced by FIELD_POLY. There are N+1 instances: N for T·B and one for LEAD, with a shared operand mux.
- The degree encoder is a function in gopf_pkg.

## Test plan
- a=x^2, b=x+1, inverter stub acks immediately with 1 → q=x+1, r=1, err=0, done in cycle 9.
- a=3x^4+x, b=0 → err=1, q=0, r=0, done in cycle 2, inv_req never high.
- a=0x0005, b=x → q=0, r=0x0005, done in cycle 2, no inv_req.
- a=2x, b=2, inverter acks 5 cycles after the request with inv(2) → q=x, r=0; inv_out=2 held stable for all 5 wait cycles.
- Two back-to-back divisions with b=2x+1:
  - Macro defined: exactly one inv_req in total.
  - Macro undefined: two inv_req.
- rst pulsed while in INV: every output is 0 on the next cycle. A following ack is ignored, and a new start for a=x^2, b=x+1 produces the correct result.
